// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks sequential, absolute or forward-jump next PC, holds across
// stalls and memory back-pressure, and parks redirects that arrive while the PC cannot move.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       jump,
    input  logic [31:0]      jump_add,
    input  logic [31:0]      jump_forward_add,
    input  logic             halt,
    input  logic             imem_ready,
    output logic [31:0]      pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic             r_pend_valid;
    logic [31:0]      r_pend_target;
    logic             r_flush;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_next_state;
    logic             w_adv;
    logic             w_jump_any;
    logic [31:0]      w_jump_target;
    logic             w_to_halt;
    logic [31:0]      w_next_pc;
    logic             w_redirect;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    assign w_jump_any    = (jump != 2'b00);
    assign w_jump_target = (jump == 2'b10) ? jump_forward_add : jump_add;
    assign w_adv         = (r_state == ST_RUN) & imem_ready & ~stall & ~halt;
    // halt only takes effect once the sequencer is running; BOOT always proceeds to RUN
    assign w_to_halt     = halt & ((r_state == ST_RUN) | (r_state == ST_HOLD));
    assign w_redirect    = w_adv & (r_pend_valid | w_jump_any);

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (r_pend_valid)    w_next_pc = r_pend_target;
        else if (w_jump_any) w_next_pc = w_jump_target;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_BOOT: w_next_state = ST_RUN;
            ST_RUN:  w_next_state = halt ? ST_HALT : (stall ? ST_HOLD : ST_RUN);
            ST_HOLD: w_next_state = halt ? ST_HALT : (stall ? ST_HOLD : ST_RUN);
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_flush      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state <= w_next_state;
            r_flush <= w_redirect;
            if (w_adv) begin
                r_pc    <= w_next_pc;
                r_count <= sat_inc(r_count);
            end
            // a jump arriving on the same adv that consumes the pending target becomes the new pending one
            if ((r_state == ST_HALT) || w_to_halt)
                r_pend_valid <= 1'b0;
            else if (w_adv)
                r_pend_valid <= r_pend_valid & w_jump_any;
            else if (w_jump_any)
                r_pend_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state != ST_HALT) && !w_to_halt && w_jump_any && (!w_adv || r_pend_valid))
            r_pend_target <= w_jump_target;
    end

    assign pc          = r_pc;
    assign fetch_valid = (r_state == ST_RUN);
    assign flush       = r_flush;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, jumps, stalls, back-pressure, wrap, saturation, halt, reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  jump;
    logic [31:0] jump_add;
    logic [31:0] jump_forward_add;
    logic        halt;
    logic        imem_ready;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        flush;
    logic [7:0]  fetch_count;

    int checks = 0;
    int failures = 0;

    pc_sequencer #(.RESET_PC(32'h100), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .jump_add(jump_add),
        .jump_forward_add(jump_forward_add), .halt(halt), .imem_ready(imem_ready),
        .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_pc, input logic e_fv,
                              input logic e_fl, input logic [7:0] e_cnt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
        chk({tag, ".cnt"}, {24'd0, fetch_count}, {24'd0, e_cnt});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; jump = 2'b00; jump_add = '0; jump_forward_add = '0;
        halt = 1'b0; imem_ready = 1'b1;
        #12;
        expect_out("reset", 32'h100, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        #1;
        expect_out("boot", 32'h100, 1'b0, 1'b0, 8'd0);
        tick(); expect_out("run0", 32'h100, 1'b1, 1'b0, 8'd0);
        tick(); expect_out("seq1", 32'h104, 1'b1, 1'b0, 8'd1);
        tick(); expect_out("seq2", 32'h108, 1'b1, 1'b0, 8'd2);

        // absolute jump
        jump = 2'b01; jump_add = 32'h400;
        tick(); expect_out("jabs", 32'h400, 1'b1, 1'b1, 8'd3);
        jump = 2'b00;
        tick(); expect_out("jabs+1", 32'h404, 1'b1, 1'b0, 8'd4);

        // stall with forward jump captured in stall cycle 2
        stall = 1'b1;
        tick(); expect_out("stall1", 32'h404, 1'b0, 1'b0, 8'd4);
        jump = 2'b10; jump_forward_add = 32'h200;
        tick(); expect_out("stall2", 32'h404, 1'b0, 1'b0, 8'd4);
        jump = 2'b00;
        tick(); expect_out("stall3", 32'h404, 1'b0, 1'b0, 8'd4);
        stall = 1'b0;
        tick(); expect_out("unstall", 32'h404, 1'b1, 1'b0, 8'd4);
        tick(); expect_out("pendfwd", 32'h200, 1'b1, 1'b1, 8'd5);
        tick(); expect_out("pendfwd+1", 32'h204, 1'b1, 1'b0, 8'd6);

        // back-pressure, newest redirect wins
        imem_ready = 1'b0; jump = 2'b01; jump_add = 32'h300;
        tick(); expect_out("bp1", 32'h204, 1'b1, 1'b0, 8'd6);
        jump = 2'b10; jump_forward_add = 32'h500;
        tick(); expect_out("bp2", 32'h204, 1'b1, 1'b0, 8'd6);
        imem_ready = 1'b1; jump = 2'b00;
        tick(); expect_out("newest", 32'h500, 1'b1, 1'b1, 8'd7);
        tick(); expect_out("newest+1", 32'h504, 1'b1, 1'b0, 8'd8);

        // pending used while a fresh jump becomes pending
        imem_ready = 1'b0; jump = 2'b11; jump_add = 32'h600;
        tick(); expect_out("bp3", 32'h504, 1'b1, 1'b0, 8'd8);
        imem_ready = 1'b1; jump = 2'b10; jump_forward_add = 32'h700;
        tick(); expect_out("pendfirst", 32'h600, 1'b1, 1'b1, 8'd9);
        jump = 2'b00;
        tick(); expect_out("pendsecond", 32'h700, 1'b1, 1'b1, 8'd10);
        tick(); expect_out("pend+1", 32'h704, 1'b1, 1'b0, 8'd11);

        // wrap
        jump = 2'b01; jump_add = 32'hFFFF_FFFC;
        tick(); expect_out("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 8'd12);
        jump = 2'b00;
        tick(); expect_out("wrap", 32'h0, 1'b1, 1'b0, 8'd13);

        // saturation of the 8-bit counter
        for (int i = 0; i < 250; i++) tick();
        expect_out("sat", 32'h3E8, 1'b1, 1'b0, 8'hFF);
        tick(); expect_out("sat+1", 32'h3EC, 1'b1, 1'b0, 8'hFF);

        // halt beats jump, then jump is ignored in HALT
        halt = 1'b1; jump = 2'b01; jump_add = 32'h900;
        tick(); expect_out("halt", 32'h3EC, 1'b0, 1'b0, 8'hFF);
        halt = 1'b0;
        tick(); expect_out("halted", 32'h3EC, 1'b0, 1'b0, 8'hFF);
        tick(); expect_out("halted2", 32'h3EC, 1'b0, 1'b0, 8'hFF);

        // asynchronous reset mid-cycle
        jump = 2'b00;
        #3 rst_n = 1'b0;
        #1 expect_out("asyncrst", 32'h100, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick(); expect_out("reboot", 32'h100, 1'b1, 1'b0, 8'd0);
        tick(); expect_out("reboot+1", 32'h104, 1'b1, 1'b0, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
